// File: rtl/pe_psum_collector_if.sv
// pe_psum_collector_if: bundles the two rdy/ack channels of the psum collector.
//   Psum_*  : PE -> collector beat channel (PEROW words per beat)
//   Gb_*    : collector -> GLB word write channel
// The collector uses the slave modport; the PE/GLB side (or a bench) uses master.
interface pe_psum_collector_if #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 24,
    parameter int AWD     = 12
);
    logic                      Psum_rdy;
    logic                      Psum_ack;
    logic signed [PSUMDWD-1:0] i_Psum [PEROW];
    logic                      Gb_rdy;
    logic                      Gb_ack;
    logic signed [PSUMDWD-1:0] o_Gb_data;
    logic [AWD-1:0]            o_Gb_addr;

    modport slave (
        input  Psum_rdy, i_Psum, Gb_ack,
        output Psum_ack, Gb_rdy, o_Gb_data, o_Gb_addr
    );

    modport master (
        output Psum_rdy, i_Psum, Gb_ack,
        input  Psum_ack, Gb_rdy, o_Gb_data, o_Gb_addr
    );
endinterface

// File: rtl/pe_psum_collector.sv
// pe_psum_collector: receives PEROW-wide psum beats from a PE into a small beat
// FIFO, serialises each beat one word per transfer and writes the words to a GLB
// write port at an auto-incrementing (wrapping) address.
// Optional feature macro: PSUM_COLLECT_RELU_EN -- when defined, negative words
// are clamped to zero on the output path; otherwise raw psums are written.
module pe_psum_collector #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 24,
    parameter int DEPTH   = 2,
    parameter int AWD     = 12,
    parameter int NBWD    = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [AWD-1:0]          i_base_addr,
    input  logic [NBWD-1:0]         i_nbeat,
    pe_psum_collector_if.slave      bus,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IDXW = (PEROW > 1) ? $clog2(PEROW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q;
    logic [AWD-1:0]             addr_q;
    logic [NBWD-1:0]            beats_left_q;
    logic [IDXW-1:0]            word_idx_q;
    logic [PTRW-1:0]            wr_ptr_q;
    logic [PTRW-1:0]            rd_ptr_q;
    logic [CNTW-1:0]            count_q;
    logic                       done_q;
    logic [PSUMDWD-1:0]         mem_q [DEPTH][PEROW];

    logic                       full_s;
    logic                       empty_s;
    logic                       push_s;
    logic                       wr_s;
    logic                       pop_s;
    logic                       last_word_s;
    logic [PSUMDWD-1:0]         head_word_s;
    logic [PSUMDWD-1:0]         out_word_s;

    assign full_s      = (count_q == CNTW'(DEPTH));
    assign empty_s     = (count_q == {CNTW{1'b0}});
    assign last_word_s = (word_idx_q == IDXW'(PEROW - 1));

    // Beat acceptance depends only on registered state: a pop in this cycle
    // does not free space until the next one.
    assign bus.Psum_ack = (state_q == ST_RUN) && bus.Psum_rdy && !full_s;
    assign push_s       = bus.Psum_ack;

    assign bus.Gb_rdy   = !empty_s;
    assign wr_s         = bus.Gb_rdy && bus.Gb_ack;
    assign pop_s        = wr_s && last_word_s;

    assign bus.o_Gb_addr = addr_q;
    assign bus.o_Gb_data = out_word_s;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;

    // Select the head word and apply the optional output transform; an empty
    // FIFO presents zero so stale entries never appear on the bus.
    always_comb begin
        head_word_s = mem_q[rd_ptr_q][word_idx_q];
        out_word_s  = {PSUMDWD{1'b0}};
        if (empty_s) begin
            out_word_s = {PSUMDWD{1'b0}};
        end else begin
`ifdef PSUM_COLLECT_RELU_EN
            if (head_word_s[PSUMDWD-1]) begin
                out_word_s = {PSUMDWD{1'b0}};
            end else begin
                out_word_s = head_word_s;
            end
`else
            out_word_s = head_word_s;
`endif
        end
    end

    // Beat storage: a push writes every row of the beat into the tail entry.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            for (int r = 0; r < PEROW; r++) begin
                mem_q[wr_ptr_q][r] <= bus.i_Psum[r];
            end
        end
    end

    // Run control FSM, FIFO pointers/occupancy, word index and address counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= {AWD{1'b0}};
            beats_left_q <= {NBWD{1'b0}};
            word_idx_q   <= {IDXW{1'b0}};
            wr_ptr_q     <= {PTRW{1'b0}};
            rd_ptr_q     <= {PTRW{1'b0}};
            count_q      <= {CNTW{1'b0}};
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q       <= i_base_addr;
                        beats_left_q <= i_nbeat;
                        word_idx_q   <= {IDXW{1'b0}};
                        if (i_nbeat == {NBWD{1'b0}}) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (push_s) begin
                        beats_left_q <= beats_left_q - NBWD'(1);
                        if (beats_left_q == NBWD'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // No pushes happen here, so the last pop empties the FIFO.
                    if (pop_s && (count_q == CNTW'(1))) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (wr_s) begin
                addr_q <= addr_q + AWD'(1);
                if (last_word_s) begin
                    word_idx_q <= {IDXW{1'b0}};
                end else begin
                    word_idx_q <= word_idx_q + IDXW'(1);
                end
            end

            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end

            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_psum_collector.sv
// Testbench for pe_psum_collector: randomized PE/GLB traffic checked against a
// list-of-words reference model built directly from the beats and run config.
module tb_pe_psum_collector;
    typedef logic signed [23:0] word_t;
    typedef word_t beat_t [4];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [9:0]  nbeat;
    logic        busy;
    logic        done;

    pe_psum_collector_if #(.PEROW(4), .PSUMDWD(24), .AWD(12)) bus();

    pe_psum_collector #(.PEROW(4), .PSUMDWD(24), .DEPTH(2), .AWD(12), .NBWD(10)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_nbeat(nbeat), .bus(bus), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int    tests_run = 0;
    int    tests_failed = 0;
    beat_t beats_q[$];
    int    got_addr[$];
    word_t got_data[$];
    int    got_cyc[$];
    int    acc_cyc[$];
    int    done_cyc[$];
    int    exp_addr[$];
    word_t exp_data[$];
    int    acked_stall;
    bit    timed_out;

    function automatic word_t ref_word(input word_t w);
`ifdef PSUM_COLLECT_RELU_EN
        return (w < 0) ? 24'sd0 : w;
`else
        return w;
`endif
    endfunction

    // Reference model: nb beats, row-major, consecutive addresses mod 4096.
    function automatic void build_expected(input int base, input int nb);
        exp_addr.delete();
        exp_data.delete();
        for (int b = 0; b < nb; b++) begin
            for (int r = 0; r < 4; r++) begin
                exp_addr.push_back((base + b * 4 + r) % 4096);
                exp_data.push_back(ref_word(beats_q[b][r]));
            end
        end
    endfunction

    function automatic void fill_random_beats(input int n);
        beat_t bt;
        beats_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 4; r++) bt[r] = word_t'($urandom());
            beats_q.push_back(bt);
        end
    endfunction

    // Drives one run (called at posedge+1) and records every observed transfer.
    task automatic run_collect(input logic [11:0] base, input int nb, input int ack_pct,
                               input int rdy_pct, input int stall, input int mid_start,
                               input int max_cyc);
        int idx = 0;
        int cyc = 0;
        int after = -1;
        bit beat_xfer;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        acc_cyc.delete(); done_cyc.delete();
        acked_stall = 0;
        timed_out = 1'b0;
        bus.Psum_rdy = 1'b0;
        bus.Gb_ack = 1'b0;
        start = 1'b1; base_addr = base; nbeat = nb[9:0];
        @(posedge clk); #1;
        start = 1'b0;
        while (1) begin
            if (cyc == mid_start) begin
                start = 1'b1; base_addr = ~base; nbeat = 10'd7;
            end else begin
                start = 1'b0;
            end
            if (!bus.Psum_rdy && idx < beats_q.size() && int'($urandom_range(99, 0)) < rdy_pct) begin
                bus.Psum_rdy = 1'b1;
                bus.i_Psum = beats_q[idx];
            end
            bus.Gb_ack = (cyc >= stall) && (int'($urandom_range(99, 0)) < ack_pct);
            @(negedge clk);
            beat_xfer = bus.Psum_rdy && bus.Psum_ack;
            if (beat_xfer) acc_cyc.push_back(cyc);
            if (bus.Gb_rdy && bus.Gb_ack) begin
                got_addr.push_back(int'(bus.o_Gb_addr));
                got_data.push_back(bus.o_Gb_data);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                if (after < 0) after = 4;
            end
            if (cyc == stall - 1) acked_stall = acc_cyc.size();
            @(posedge clk); #1;
            if (beat_xfer) begin
                bus.Psum_rdy = 1'b0;
                idx++;
            end
            cyc++;
            if (after > 0) after--;
            if (after == 0) break;
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
        end
        bus.Psum_rdy = 1'b0;
        bus.Gb_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.Psum_rdy = 1'b1; bus.Gb_ack = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.Psum_ack !== 1'b0 || bus.Gb_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ack=%b gb_rdy=%b busy=%b done=%b, expected all 0",
                     bus.Psum_ack, bus.Gb_rdy, busy, done);
        end
        tests_run++;
        if (bus.o_Gb_data !== 24'sd0 || bus.o_Gb_addr !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_bus: data=%0d addr=%h, expected 0/000", bus.o_Gb_data, bus.o_Gb_addr);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (bus.Psum_ack !== 1'b0 || bus.Gb_rdy !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_after_reset: ack=%b gb_rdy=%b busy=%b, expected 0",
                         bus.Psum_ack, bus.Gb_rdy, busy);
            end
        end
        @(posedge clk); #1;
        bus.Psum_rdy = 1'b0; bus.Gb_ack = 1'b0;
    endtask

    task automatic test_single_beat;
        beat_t bt;
        int last;
        bt[0] = 24'sd5; bt[1] = -24'sd3; bt[2] = 24'sd7; bt[3] = 24'sd0;
        beats_q.delete(); beats_q.push_back(bt);
        run_collect(12'h010, 1, 100, 100, 0, -1, 60);
        build_expected(12'h010, 1);
        tests_run++;
        if (got_addr.size() != exp_addr.size()) begin
            tests_failed++;
            $display("FAIL single_count: got %0d words, expected %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL single_word%0d: got (%h,%0d), expected (%h,%0d)",
                         i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        last = (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] : -100;
        tests_run++;
        if (timed_out || done_cyc.size() != 1 || done_cyc[0] != last + 1) begin
            tests_failed++;
            $display("FAIL single_done: timeout=%0d done_pulses=%0d last_write=%0d, expected one pulse at %0d",
                     timed_out, done_cyc.size(), last, last + 1);
        end
        tests_run++;
        if (acc_cyc.size() != 1 || got_cyc.size() == 0 || got_cyc[0] != acc_cyc[0] + 1) begin
            tests_failed++;
            $display("FAIL single_latency: accepts=%0d first_write_cycle=%0d, expected accept+1",
                     acc_cyc.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] base = 12'($urandom());
        fill_random_beats(5);
        run_collect(base, 4, 100, 100, 20, -1, 200);
        build_expected(int'(base), 4);
        tests_run++;
        if (acked_stall != 2) begin
            tests_failed++;
            $display("FAIL bp_stall_acks: got %0d beats acked while GLB stalled, expected 2", acked_stall);
        end
        tests_run++;
        if (timed_out || acc_cyc.size() != 4 || got_addr.size() != 16) begin
            tests_failed++;
            $display("FAIL bp_counts: timeout=%0d acks=%0d words=%0d, expected 0/4/16",
                     timed_out, acc_cyc.size(), got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got (%h,%0d), expected (%h,%0d)",
                         i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_wrap;
        fill_random_beats(1);
        run_collect(12'hFFE, 1, 100, 100, 0, -1, 60);
        build_expected(12'hFFE, 1);
        tests_run++;
        if (got_addr.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d words, expected 4", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL wrap_word%0d: got (%h,%0d), expected (%h,%0d)",
                         i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_nbeat_zero;
        bus.Psum_rdy = 1'b1; bus.Gb_ack = 1'b1;
        start = 1'b1; base_addr = 12'h123; nbeat = 10'd0;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.Psum_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL nbeat0_done: done=%b busy=%b ack=%b, expected 1/0/0", done, busy, bus.Psum_ack);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || bus.Psum_ack !== 1'b0 || bus.Gb_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nbeat0_after: done=%b ack=%b gb_rdy=%b, expected 0/0/0",
                     done, bus.Psum_ack, bus.Gb_rdy);
        end
        @(posedge clk); #1;
        bus.Psum_rdy = 1'b0; bus.Gb_ack = 1'b0;
    endtask

    task automatic test_start_midrun;
        logic [11:0] base = 12'($urandom());
        fill_random_beats(3);
        run_collect(base, 3, 60, 80, 0, 5, 300);
        build_expected(int'(base), 3);
        tests_run++;
        if (timed_out || got_addr.size() != 12 || done_cyc.size() != 1) begin
            tests_failed++;
            $display("FAIL midstart_counts: timeout=%0d words=%0d done_pulses=%0d, expected 0/12/1",
                     timed_out, got_addr.size(), done_cyc.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL midstart_word%0d: got (%h,%0d), expected (%h,%0d)",
                         i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_middrain;
        fill_random_beats(2);
        run_collect(12'h200, 2, 100, 100, 1000, -1, 10);
        tests_run++;
        if (acc_cyc.size() != 2 || busy !== 1'b1 || bus.Gb_rdy !== 1'b1 || got_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_setup: acks=%0d busy=%b gb_rdy=%b words=%0d, expected 2/1/1/0",
                     acc_cyc.size(), busy, bus.Gb_rdy, got_addr.size());
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.Gb_rdy !== 1'b0 || busy !== 1'b0 || bus.o_Gb_addr !== 12'h000) begin
            tests_failed++;
            $display("FAIL drain_reset: gb_rdy=%b busy=%b addr=%h, expected 0/0/000",
                     bus.Gb_rdy, busy, bus.o_Gb_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.Gb_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (bus.Gb_rdy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_after_reset: gb_rdy=%b done=%b, expected 0/0", bus.Gb_rdy, done);
            end
        end
        @(posedge clk); #1;
        bus.Gb_ack = 1'b0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int nb = int'($urandom_range(10, 1));
            logic [11:0] base = 12'($urandom());
            int ap = int'($urandom_range(100, 20));
            int rp = int'($urandom_range(100, 20));
            int last;
            fill_random_beats(nb + int'($urandom_range(2, 0)));
            run_collect(base, nb, ap, rp, 0, -1, 2000);
            build_expected(int'(base), nb);
            last = (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] : -100;
            tests_run++;
            if (timed_out || acc_cyc.size() != nb || got_addr.size() != exp_addr.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_counts: timeout=%0d acks=%0d words=%0d, expected 0/%0d/%0d",
                         it, timed_out, acc_cyc.size(), got_addr.size(), nb, exp_addr.size());
            end
            tests_run++;
            if (done_cyc.size() != 1 || done_cyc[0] != last + 1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand%0d_done: pulses=%0d last_write=%0d busy=%b, expected 1 pulse at %0d, busy 0",
                         it, done_cyc.size(), last, busy, last + 1);
            end
            for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
                tests_run++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_word%0d: got (%h,%0d), expected (%h,%0d)",
                             it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_relu;
        beat_t bt;
        bt[0] = -24'sd1; bt[1] = 24'sd2; bt[2] = -24'sd8; bt[3] = 24'sd3;
        beats_q.delete(); beats_q.push_back(bt);
        run_collect(12'h040, 1, 100, 100, 0, -1, 60);
        build_expected(12'h040, 1);
        tests_run++;
        if (got_data.size() != 4) begin
            tests_failed++;
            $display("FAIL relu_count: got %0d words, expected 4", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            tests_run++;
            if (got_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL relu_word%0d: got %0d, expected %0d", i, got_data[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 12'h000;
        nbeat = 10'd0;
        bus.Psum_rdy = 1'b0;
        bus.Gb_ack = 1'b0;
        for (int r = 0; r < 4; r++) bus.i_Psum[r] = 24'sd0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_wrap();
        test_nbeat_zero();
        test_start_midrun();
        test_reset_middrain();
        test_relu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
